// File: rtl/game_flow_ctrl_if.sv
// Control/status bundle between the game flow controller and its surroundings.
// master = stimulus side (buttons, ticks, timer), slave = the controller.
interface game_flow_ctrl_if;
  logic        i_tick;
  logic        btn_start;
  logic        btn_pause;
  logic [31:0] i_song_len_ms;
  logic [31:0] i_cur_time;
  logic        o_timer_clr;
  logic        o_timer_tick;
  logic [2:0]  o_state;
  logic [1:0]  o_countdown;
  logic        o_playing;
  logic        o_game_over;
  logic [31:0] o_remain_ms;

  modport master (
    output i_tick, btn_start, btn_pause, i_song_len_ms, i_cur_time,
    input  o_timer_clr, o_timer_tick, o_state, o_countdown, o_playing,
           o_game_over, o_remain_ms
  );

  modport slave (
    input  i_tick, btn_start, btn_pause, i_song_len_ms, i_cur_time,
    output o_timer_clr, o_timer_tick, o_state, o_countdown, o_playing,
           o_game_over, o_remain_ms
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Round sequencer: IDLE -> COUNTDOWN -> RUN (<-> PAUSE) -> DONE, gating the game timer.
// Define GAME_FLOW_PAUSE_EN to enable the PAUSE state; otherwise btn_pause is ignored.
module game_flow_ctrl #(
  parameter int unsigned STEP_MS  = 1000,
  parameter int unsigned CD_STEPS = 3
) (
  input  logic             clk,
  input  logic             rst,
  game_flow_ctrl_if.slave  bus
);

  localparam int unsigned    MS_W    = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(STEP_MS - 1);
  localparam logic [1:0]      CD_INIT = 2'(CD_STEPS);

  // Encoding is fixed so o_state is simply the state register.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUN       = 3'd2,
    S_PAUSE     = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     len_q, len_d;
  logic [1:0]      cd_q, cd_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic            clr_q, clr_d;
  logic            time_up;
  logic            pause_req;

  // Timer may overshoot len_q, so end on >= rather than ==.
  assign time_up = (bus.i_cur_time >= len_q);

`ifdef GAME_FLOW_PAUSE_EN
  assign pause_req = bus.btn_pause;
`else
  logic unused_btn_pause;
  assign unused_btn_pause = bus.btn_pause;
  assign pause_req        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cd_q    <= '0;
      ms_q    <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cd_q    <= cd_d;
      ms_q    <= ms_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cd_d    = cd_q;
    ms_d    = ms_q;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.btn_start) begin
          state_d = S_COUNTDOWN;
          len_d   = bus.i_song_len_ms;
          cd_d    = CD_INIT;
          ms_d    = '0;
          clr_d   = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (bus.i_tick) begin
          if (ms_q == MS_LAST) begin
            ms_d = '0;
            if (cd_q > 2'd1) begin
              cd_d = cd_q - 2'd1;
            end else begin
              cd_d    = '0;
              state_d = S_RUN;
            end
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (time_up) begin
          state_d = S_DONE;
        end else if (pause_req) begin
          state_d = S_PAUSE;
        end
      end
`ifdef GAME_FLOW_PAUSE_EN
      S_PAUSE: begin
        if (bus.btn_start) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end else if (pause_req) begin
          state_d = S_RUN;
        end
      end
`endif
      S_DONE: begin
        if (bus.btn_start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_state      = state_q;
    bus.o_timer_clr  = clr_q;
    bus.o_timer_tick = bus.i_tick && (state_q == S_RUN);
    bus.o_playing    = (state_q == S_RUN);
    bus.o_game_over  = (state_q == S_DONE);
    bus.o_countdown  = (state_q == S_COUNTDOWN) ? cd_q : 2'd0;
    bus.o_remain_ms  = '0;
    case (state_q)
      S_COUNTDOWN:    bus.o_remain_ms = len_q;
      S_RUN, S_PAUSE: bus.o_remain_ms = time_up ? 32'd0 : (len_q - bus.i_cur_time);
      default:        bus.o_remain_ms = '0;
    endcase
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed, table-driven bench for game_flow_ctrl (STEP_MS=4, CD_STEPS=3, tick every 5 clk).
// Follows GAME_FLOW_PAUSE_EN so either build of the controller can be checked.
module tb_game_flow_ctrl;

  typedef struct {
    logic        start;
    logic        pause;
    int          ticks;
    logic [31:0] len;
    logic        exp_clr;
    logic [2:0]  exp_state;
    logic [1:0]  exp_cd;
    logic [31:0] exp_remain;
    logic [31:0] exp_cur;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] model_time;
  int          n_tests;
  int          n_fail;
  vec_t        vecs[$];

  game_flow_ctrl_if bus_if ();

  game_flow_ctrl #(.STEP_MS(4), .CD_STEPS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external game timer driven by the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      model_time <= '0;
    else if (bus_if.o_timer_clr)  model_time <= '0;
    else if (bus_if.o_timer_tick) model_time <= model_time + 32'd1;
  end
  assign bus_if.i_cur_time = model_time;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic p, input logic t);
    bus_if.btn_start = s;
    bus_if.btn_pause = p;
    bus_if.i_tick    = t;
    @(posedge clk);
    #1;
    bus_if.btn_start = 1'b0;
    bus_if.btn_pause = 1'b0;
    bus_if.i_tick    = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] st, input logic [1:0] cd,
                             input logic [31:0] rem, input logic [31:0] cur);
    checkOutput({tag, ".state"}, 32'(bus_if.o_state), 32'(st));
    checkOutput({tag, ".countdown"}, 32'(bus_if.o_countdown), 32'(cd));
    checkOutput({tag, ".remain"}, bus_if.o_remain_ms, rem);
    checkOutput({tag, ".cur_time"}, model_time, cur);
    checkOutput({tag, ".playing"}, 32'(bus_if.o_playing), 32'(st == 3'd2));
    checkOutput({tag, ".game_over"}, 32'(bus_if.o_game_over), 32'(st == 3'd4));
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    bus_if.i_song_len_ms = v.len;
    cyc(v.start, v.pause, 1'b0);
    checkOutput({tag, ".timer_clr"}, 32'(bus_if.o_timer_clr), 32'(v.exp_clr));
    run_ticks(v.ticks);
    check_state(tag, v.exp_state, v.exp_cd, v.exp_remain, v.exp_cur);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus_if.i_tick        = 1'b0;
    bus_if.btn_start     = 1'b0;
    bus_if.btn_pause     = 1'b0;
    bus_if.i_song_len_ms = 32'd20;

    // start, pause, ticks, len, clr, state, cd, remain, cur
    vecs.push_back('{1'b0, 1'b0, 0,  32'd20, 1'b0, 3'd0, 2'd0, 32'd0,  32'd0});
    vecs.push_back('{1'b1, 1'b0, 0,  32'd20, 1'b1, 3'd1, 2'd3, 32'd20, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 4,  32'd99, 1'b0, 3'd1, 2'd2, 32'd20, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 4,  32'd99, 1'b0, 3'd1, 2'd1, 32'd20, 32'd0});
    vecs.push_back('{1'b1, 1'b0, 3,  32'd99, 1'b0, 3'd1, 2'd1, 32'd20, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1,  32'd99, 1'b0, 3'd2, 2'd0, 32'd20, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 7,  32'd99, 1'b0, 3'd2, 2'd0, 32'd13, 32'd7});
    vecs.push_back('{1'b1, 1'b0, 0,  32'd99, 1'b0, 3'd2, 2'd0, 32'd13, 32'd7});
`ifdef GAME_FLOW_PAUSE_EN
    vecs.push_back('{1'b0, 1'b1, 10, 32'd99, 1'b0, 3'd3, 2'd0, 32'd13, 32'd7});
    vecs.push_back('{1'b0, 1'b1, 1,  32'd99, 1'b0, 3'd2, 2'd0, 32'd12, 32'd8});
    vecs.push_back('{1'b0, 1'b0, 12, 32'd99, 1'b0, 3'd4, 2'd0, 32'd0,  32'd20});
`else
    vecs.push_back('{1'b0, 1'b1, 10, 32'd99, 1'b0, 3'd2, 2'd0, 32'd3,  32'd17});
    vecs.push_back('{1'b0, 1'b1, 1,  32'd99, 1'b0, 3'd2, 2'd0, 32'd2,  32'd18});
    vecs.push_back('{1'b0, 1'b0, 2,  32'd99, 1'b0, 3'd4, 2'd0, 32'd0,  32'd20});
`endif
    vecs.push_back('{1'b0, 1'b1, 2,  32'd99, 1'b0, 3'd4, 2'd0, 32'd0,  32'd20});
    vecs.push_back('{1'b1, 1'b0, 0,  32'd99, 1'b0, 3'd0, 2'd0, 32'd0,  32'd20});
    vecs.push_back('{1'b0, 1'b1, 2,  32'd99, 1'b0, 3'd0, 2'd0, 32'd0,  32'd20});

    repeat (3) @(posedge clk);
    #1;
    check_state("in_reset", 3'd0, 2'd0, 32'd0, 32'd0);
    checkOutput("in_reset.timer_clr", 32'(bus_if.o_timer_clr), 32'd0);
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check_state("post_reset", 3'd0, 2'd0, 32'd0, 32'd0);
    checkOutput("post_reset.timer_clr", 32'(bus_if.o_timer_clr), 32'd0);

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Zero-length round: DONE one cycle after RUN is entered.
    bus_if.i_song_len_ms = 32'd0;
    cyc(1'b1, 1'b0, 1'b0);
    checkOutput("len0.timer_clr", 32'(bus_if.o_timer_clr), 32'd1);
    run_ticks(11);
    cyc(1'b0, 1'b0, 1'b1);
    check_state("len0.run", 3'd2, 2'd0, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check_state("len0.done", 3'd4, 2'd0, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    checkOutput("len0.idle", 32'(bus_if.o_state), 32'd0);

    // Pause arriving with the end condition: DONE wins.
    bus_if.i_song_len_ms = 32'd5;
    cyc(1'b1, 1'b0, 1'b0);
    run_ticks(12);
    run_ticks(4);
    cyc(1'b0, 1'b0, 1'b1);
    check_state("race.run", 3'd2, 2'd0, 32'd0, 32'd5);
    cyc(1'b0, 1'b1, 1'b0);
    check_state("race.done", 3'd4, 2'd0, 32'd0, 32'd5);
    cyc(1'b1, 1'b0, 1'b0);

    // Both buttons while paused: abort wins and clears the timer.
    bus_if.i_song_len_ms = 32'd20;
    cyc(1'b1, 1'b0, 1'b0);
    run_ticks(12);
    run_ticks(2);
    cyc(1'b0, 1'b1, 1'b0);
`ifdef GAME_FLOW_PAUSE_EN
    check_state("abort.pause", 3'd3, 2'd0, 32'd18, 32'd2);
    cyc(1'b1, 1'b1, 1'b0);
    checkOutput("abort.timer_clr", 32'(bus_if.o_timer_clr), 32'd1);
    check_state("abort.idle", 3'd0, 2'd0, 32'd0, 32'd2);
    cyc(1'b0, 1'b0, 1'b0);
    checkOutput("abort.clr_end", 32'(bus_if.o_timer_clr), 32'd0);
    checkOutput("abort.cur_clr", model_time, 32'd0);
`else
    check_state("nopause.run", 3'd2, 2'd0, 32'd18, 32'd2);
    bus_if.i_tick = 1'b1;
    #1;
    checkOutput("nopause.timer_tick", 32'(bus_if.o_timer_tick), 32'd1);
    bus_if.i_tick = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
`endif

    // Reset mid-countdown: immediate return to IDLE, no clear pulse afterwards.
    cyc(1'b1, 1'b0, 1'b0);
    run_ticks(5);
    checkOutput("rst_mid.cd_before", 32'(bus_if.o_countdown), 32'd2);
    rst = 1'b1;
    #1;
    check_state("rst_mid.async", 3'd0, 2'd0, 32'd0, 32'd0);
    checkOutput("rst_mid.timer_clr", 32'(bus_if.o_timer_clr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      cyc(1'b0, 1'b0, 1'b0);
      checkOutput("rst_mid.no_clr", 32'(bus_if.o_timer_clr), 32'd0);
    end
    check_state("rst_mid.idle", 3'd0, 2'd0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter: STEP_MS, 1000, countdown step length in 1 ms ticks (minimum 1).
REQ-002 Parameter: CD_STEPS, 3, number of countdown steps before play (range 1..3).
REQ-003 Port: clk  in  1  system clock.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: i_tick  in  1  1 ms tick from divider, one clk wide.
REQ-006 Port: btn_start  in  1  debounced start/abort pulse, one clk wide.
REQ-007 Port: btn_pause  in  1  debounced pause/resume pulse, one clk wide.
REQ-008 Port: i_song_len_ms  in  32  round length in ms, sampled at start.
REQ-009 Port: i_cur_time  in  32  elapsed ms from the game timer.
REQ-010 Port: o_timer_clr  out  1  one-cycle clear pulse to the game timer's reset.
REQ-011 Port: o_timer_tick  out  1  gated tick to the game timer.
REQ-012 Port: o_state  out  3  IDLE=0, COUNTDOWN=1, RUN=2, PAUSE=3, DONE=4.
REQ-013 Port: o_countdown  out  2  displayed countdown digit; 0 outside COUNTDOWN.
REQ-014 Port: o_playing  out  1  high only in RUN.
REQ-015 Port: o_game_over  out  1  high only in DONE.
REQ-016 Port: o_remain_ms  out  32  remaining round time.

Function
REQ-017 The block SHALL be a single registered FSM with states IDLE, COUNTDOWN, RUN, PAUSE and DONE; state outputs SHALL follow the registered state with no added latency.
REQ-018 IDLE + btn_start SHALL, on the next edge, latch i_song_len_ms into len_q, set cd_q=CD_STEPS and ms_q=0, enter COUNTDOWN, and assert o_timer_clr for exactly that one cycle.
REQ-019 COUNTDOWN: each i_tick SHALL increment ms_q.
- When a tick arrives with ms_q==STEP_MS-1 and cd_q>1: ms_q<=0, cd_q<=cd_q-1.
- When that tick arrives with cd_q==1: go to RUN.
REQ-020 o_countdown SHALL equal cd_q in COUNTDOWN and 0 in every other state.
REQ-021 o_timer_tick SHALL equal i_tick AND (state==RUN), combinational, with zero latency; the game timer SHALL NOT advance in any other state.
REQ-022 RUN: when i_cur_time >= len_q, the FSM SHALL enter DONE on the next edge; len_q==0 SHALL therefore end the round on the first RUN cycle.
REQ-023 RUN + btn_pause SHALL enter PAUSE; if the end condition holds in the same cycle, DONE SHALL win.
REQ-024 PAUSE + btn_pause SHALL return to RUN with i_cur_time unchanged. PAUSE + btn_start SHALL abort to IDLE and pulse o_timer_clr for one cycle; btn_start SHALL win if both buttons arrive together.
REQ-025 DONE SHALL hold until btn_start, which SHALL go to IDLE only; a new round needs a second btn_start.
REQ-026 btn_start in COUNTDOWN or RUN, and btn_pause in IDLE, COUNTDOWN or DONE, SHALL be ignored.
REQ-027 o_remain_ms SHALL be len_q - i_cur_time, saturating at 0, in RUN and PAUSE; it SHALL be len_q in COUNTDOWN and 0 in IDLE and DONE.
REQ-028 Arithmetic SHALL be unsigned 32-bit; ms_q SHALL be at least ceil(log2(STEP_MS)) bits wide; i_cur_time SHALL NOT be assumed to stop exactly at len_q.

Reset
REQ-029 rst SHALL asynchronously force state=IDLE, len_q=0, cd_q=0 and ms_q=0, and drive every output to 0, including o_timer_clr.
REQ-030 rst asserted mid-round SHALL abandon the round without emitting o_timer_clr; the game timer is reset by the same rst.

Configuration
REQ-031 With GAME_FLOW_PAUSE_EN defined, the PAUSE state and the btn_pause behaviour of REQ-023 and REQ-024 SHALL be present.
REQ-032 Without GAME_FLOW_PAUSE_EN, btn_pause SHALL be ignored, PAUSE SHALL be unreachable, and the encoding of REQ-012 SHALL be unchanged.

Verification (STEP_MS=4, CD_STEPS=3, i_tick every 5 clk)
REQ-033 rst held, then released -> all outputs 0 and o_state=0 until btn_start.
REQ-034 btn_start with i_song_len_ms=20 -> one-cycle o_timer_clr; o_countdown 3,2,1 for 4 ticks each; o_state=2 on the 12th tick.
REQ-035 In RUN, model timer reaching 20 -> o_state=4 next cycle, o_game_over=1, o_remain_ms=0, o_timer_tick stays 0 afterwards.
REQ-036 btn_pause at cur_time=7, 10 ticks, then btn_pause again -> cur_time stays 7 while paused, o_remain_ms=13, resumes counting at 8 (macro defined); macro undefined -> pauses ignored, round ends at 20.
REQ-037 btn_pause in the same cycle that cur_time reaches len_q -> DONE, not PAUSE. btn_start and btn_pause together in PAUSE -> IDLE plus o_timer_clr.
REQ-038 i_song_len_ms=0 -> DONE one cycle after entering RUN. rst pulse mid-COUNTDOWN -> IDLE immediately, o_countdown=0.
